// File: rtl/out_port_bcd_seg.sv
// Sequential binary-to-BCD stage driving a two-digit active-low seven-segment pair.
// Optional feature: define OUT_SEG_LZB_EN to blank a leading zero on the tens digit.
module out_port_bcd_seg #(
    parameter int DATA_W = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] out_port,
    output logic [6:0]  out_high,
    output logic [6:0]  out_low,
    output logic        busy,
    output logic        done,
    output logic        ovf
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] CONV  = 2'd1;
    localparam logic [1:0] LATCH = 2'd2;

    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_ZERO  = 7'b1000000;

`ifdef OUT_SEG_LZB_EN
    localparam logic [6:0] HIGH_RESET = SEG_BLANK;
`else
    localparam logic [6:0] HIGH_RESET = SEG_ZERO;
`endif

    logic [1:0]        state;
    logic [DATA_W-1:0] last;
    logic              hi_nz;
    logic [DATA_W-1:0] sh;
    logic [11:0]       bcd;
    logic [11:0]       bcd_adj;
    logic [3:0]        cnt;
    logic              upper_nz;
    logic              trigger;
    logic              overflow;
    logic [6:0]        high_glyph;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = SEG_BLANK;
        endcase
    endfunction

    assign upper_nz = |out_port[31:DATA_W];
    assign trigger  = (out_port[DATA_W-1:0] != last) || (upper_nz != hi_nz);
    assign overflow = hi_nz || (bcd[11:8] != 4'd0);
    assign busy     = (state != IDLE);

    // Double-dabble correction: any nibble >= 5 would exceed 9 after the shift.
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < 3; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        high_glyph = seg7(bcd[7:4]);
`ifdef OUT_SEG_LZB_EN
        if (bcd[7:4] == 4'd0) begin
            high_glyph = SEG_BLANK;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            last     <= '0;
            hi_nz    <= 1'b0;
            sh       <= '0;
            bcd      <= '0;
            cnt      <= '0;
            out_high <= HIGH_RESET;
            out_low  <= SEG_ZERO;
            ovf      <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (trigger) begin
                        last  <= out_port[DATA_W-1:0];
                        hi_nz <= upper_nz;
                        sh    <= out_port[DATA_W-1:0];
                        bcd   <= '0;
                        cnt   <= 4'(DATA_W);
                        state <= CONV;
                    end
                end
                CONV: begin
                    {bcd, sh} <= {bcd_adj, sh} << 1;
                    cnt       <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state <= LATCH;
                    end
                end
                LATCH: begin
                    // Display registers change only here, so partial BCD is never shown.
                    if (overflow) begin
                        out_high <= SEG_DASH;
                        out_low  <= SEG_DASH;
                        ovf      <= 1'b1;
                    end else begin
                        out_high <= high_glyph;
                        out_low  <= seg7(bcd[3:0]);
                        ovf      <= 1'b0;
                    end
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_out_port_bcd_seg.sv
// Self-checking bench for out_port_bcd_seg: directed vectors feed a scoreboard
// whose monitor pops one expected {ovf, out_high, out_low} per done pulse.
module tb_out_port_bcd_seg;

    localparam int LAT = 10;  // drive at cycle c -> done seen at cycle c+LAT (DATA_W=8)

    localparam logic [6:0] G_DASH = 7'b0111111;
    localparam logic [6:0] G_0    = 7'b1000000;
`ifdef OUT_SEG_LZB_EN
    localparam logic [6:0] G_HI0  = 7'b1111111;
`else
    localparam logic [6:0] G_HI0  = 7'b1000000;
`endif

    logic        clk;
    logic        reset;
    logic [31:0] out_port;
    logic [6:0]  out_high;
    logic [6:0]  out_low;
    logic        busy;
    logic        done;
    logic        ovf;

    int n_checks;
    int n_pass;
    int cyc;

    logic [14:0] exp_q[$];
    int          cyc_q[$];

    out_port_bcd_seg #(.DATA_W(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .out_port (out_port),
        .out_high (out_high),
        .out_low  (out_low),
        .busy     (busy),
        .done     (done),
        .ovf      (ovf)
    );

    // clock / reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // monitor: every done pulse must match the oldest expectation, at the right cycle
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                check("display", {17'd0, ovf, out_high, out_low}, {17'd0, exp_q.pop_front()});
                check("latency", cyc, cyc_q.pop_front());
            end
        end
    end

    // driver tasks
    task automatic drive(input logic [31:0] v, input logic [14:0] exp, input int delay_extra);
        @(negedge clk);
        out_port = v;
        exp_q.push_back(exp);
        cyc_q.push_back(cyc + LAT + delay_extra);
    endtask

    task automatic drain();
        for (int i = 0; i < 200; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        if (exp_q.size() != 0) begin
            check("drain_timeout", exp_q.size(), 0);
            exp_q.delete();
            cyc_q.delete();
        end
        @(negedge clk);
        check("busy_after", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int c0;
        logic any_busy;
        n_checks = 0;
        n_pass   = 0;
        cyc      = 0;
        reset    = 1'b1;
        out_port = 32'd0;

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("rst_high", {25'd0, out_high}, {25'd0, G_HI0});
        check("rst_low",  {25'd0, out_low},  {25'd0, G_0});
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_ovf",  {31'd0, ovf},  32'd0);
        any_busy = 1'b0;
        repeat (6) begin
            @(negedge clk);
            any_busy = any_busy | busy;
        end
        check("no_conv_after_reset", {31'd0, any_busy}, 32'd0);

        // normal values
        drive(32'd42, {1'b0, 7'b0011001, 7'b0100100}, 0);
        @(negedge clk);
        check("busy_during_conv", {31'd0, busy}, 32'd1);
        drain();
        drive(32'd99, {1'b0, 7'b0010000, 7'b0010000}, 0);
        drain();

        // low-bits overflow
        drive(32'd100, {1'b1, G_DASH, G_DASH}, 0);
        drain();
        check("ovf_100", {31'd0, ovf}, 32'd1);
        drive(32'd255, {1'b1, G_DASH, G_DASH}, 0);
        drain();

        // upper-bits overflow, then same low bits with upper bits clear
        drive(32'h8000_0005, {1'b1, G_DASH, G_DASH}, 0);
        drain();
        drive(32'h0000_0005, {1'b0, G_HI0, 7'b0010010}, 0);
        drain();
        check("ovf_clear", {31'd0, ovf}, 32'd0);

        // change mid-conversion: 58 is picked up in the IDLE cycle after LATCH
        drive(32'd37, {1'b0, 7'b0110000, 7'b1111000}, 0);
        c0 = cyc;
        repeat (3) @(negedge clk);
        out_port = 32'd58;
        exp_q.push_back({1'b0, 7'b0010010, 7'b0000000});
        cyc_q.push_back(c0 + LAT + 1 + 9);
        drain();

        // reset mid-conversion: no done, outputs back to reset values
        @(negedge clk);
        out_port = 32'd50;
        repeat (4) @(negedge clk);
        check("busy_before_abort", {31'd0, busy}, 32'd1);
        reset    = 1'b1;
        out_port = 32'd0;
        @(negedge clk);
        reset = 1'b0;
        check("abort_high", {25'd0, out_high}, {25'd0, G_HI0});
        check("abort_low",  {25'd0, out_low},  {25'd0, G_0});
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_ovf",  {31'd0, ovf},  32'd0);
        repeat (15) @(negedge clk);

        // single digit: tens blanked only with leading-zero blanking
        drive(32'd7, {1'b0, G_HI0, 7'b1111000}, 0);
        drain();

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
